// File: rtl/ahb_sram_sub.sv
// AHB SRAM subordinate with configurable wait states and byte-lane writes.
// Optional error responses are enabled with AHB_SRAM_SUB_ERR_RESP_EN.
module ahb_sram_sub #(
   parameter int unsigned DataWidth  = 32,
   parameter int unsigned AddrWidth  = 32,
   parameter int unsigned MemDepth   = 256,
   parameter int unsigned WaitStates = 0
) (
   input  logic                 clk,
   input  logic                 nReset,
   input  logic [AddrWidth-1:0] addr,
   input  logic                 write,
   input  logic [3:0]           size,
   input  logic [2:0]           trans,
   input  logic                 sel,
   input  logic                 ready,
   input  logic [DataWidth-1:0] wData,
   output logic                 readyOut,
   output logic [1:0]           resp,
   output logic [DataWidth-1:0] rData
);

   localparam int unsigned Bpw    = DataWidth / 8;
   localparam int unsigned LogBpw = $clog2(Bpw);
   localparam int unsigned IdxW   = (MemDepth > 1) ? $clog2(MemDepth) : 1;
   localparam logic [AddrWidth-1:0] DepthA   = AddrWidth'(MemDepth);
   localparam logic [3:0]           SizeMax  = 4'(LogBpw);
   localparam logic [3:0]           WaitLast = 4'((WaitStates > 0) ? WaitStates - 1 : 0);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA
`ifdef AHB_SRAM_SUB_ERR_RESP_EN
      , ST_ERR1,
      ST_ERR2
`endif
   } state_t;

   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [AddrWidth-1:0]   addr_q;
   logic                   write_q;
   logic [3:0]             size_q;
   logic                   accept;
   logic [IdxW-1:0]        idx;
   logic [LogBpw-1:0]      mask_q;
   logic [LogBpw-1:0]      off_q;
   logic [Bpw-1:0]         be;
   logic [DataWidth-1:0]   mem [MemDepth];

   // Low-address mask for a transfer size; oversize transfers collapse to a full word.
   function automatic logic [LogBpw-1:0] lane_mask(input logic [3:0] sz);
      logic [3:0]      clamp;
      logic [LogBpw:0] nbytes;
      clamp  = (sz > SizeMax) ? SizeMax : sz;
      nbytes = (LogBpw + 1)'(1) << clamp;
      return LogBpw'(nbytes - 1'b1);
   endfunction

   always_comb begin
      readyOut = (state_q != ST_WAIT);
      resp     = 2'b00;
`ifdef AHB_SRAM_SUB_ERR_RESP_EN
      if (state_q == ST_ERR1) readyOut = 1'b0;
      if (state_q == ST_ERR1 || state_q == ST_ERR2) resp = 2'b01;
`endif
   end

   assign accept = sel && ready && readyOut && (trans == 3'd2 || trans == 3'd3);

`ifdef AHB_SRAM_SUB_ERR_RESP_EN
   logic err_in;
   assign err_in = ((addr >> LogBpw) >= DepthA) || (size > SizeMax) ||
                   ((addr[LogBpw-1:0] & lane_mask(size)) != '0);
`endif

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            addr_q  <= addr;
            write_q <= write;
            size_q  <= size;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
         ST_WAIT: begin
            if (cnt_q == WaitLast) state_d = ST_DATA;
            else                   cnt_d   = cnt_q + 4'd1;
         end
`ifdef AHB_SRAM_SUB_ERR_RESP_EN
         ST_ERR1: state_d = ST_ERR2;
`endif
         default: begin
            if (!accept)                 state_d = ST_IDLE;
`ifdef AHB_SRAM_SUB_ERR_RESP_EN
            else if (err_in)             state_d = ST_ERR1;
`endif
            else if (WaitStates > 0)     state_d = ST_WAIT;
            else                         state_d = ST_DATA;
         end
      endcase
   end

   // Word index wraps by depth; lanes are the aligned block containing the offset.
   assign idx    = IdxW'((addr_q >> LogBpw) % DepthA);
   assign mask_q = lane_mask(size_q);
   assign off_q  = addr_q[LogBpw-1:0] & ~mask_q;

   always_comb begin
      be = '0;
      for (int b = 0; b < Bpw; b++) begin
         be[b] = ((LogBpw'(b) & ~mask_q) == off_q);
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == ST_DATA && write_q) begin
         for (int b = 0; b < Bpw; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wData[8*b +: 8];
         end
      end
   end

   always_comb begin
      rData = '0;
      if (state_q == ST_DATA && !write_q) rData = mem[idx];
   end

endmodule
